// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: execute-strobe sequencer for the 8-bit CPU core.
// Runs the core on a timed tick or halt/single-step, fetching each
// instruction over a req/ack handshake at the core's pc.
//
// Ports:
//   clk50            system clock, posedge
//   reset            async active-low reset
//   run_sw           1=run, 0=halt/step (async)
//   step_btn         single-step button (async, bouncy)
//   bp_addr[7:0]     breakpoint pc
//   pc[7:0]          core program counter
//   imem_req         fetch request, held until ack
//   imem_addr[7:0]   fetch address
//   imem_ack         imem_data valid this cycle
//   imem_data[7:0]   instruction word
//   instr[7:0]       latched instruction to core
//   cpu_en           one-cycle execute strobe
//   halted           1 while halted
//   bp_hit           last halt came from the breakpoint
//
// Build option: define CPU_BREAKPOINT_EN to build the breakpoint
// comparator; without it bp_addr is ignored and bp_hit stays 0.
module cpu_step_ctrl #(
  parameter int DIV       = 25_000_000,
  parameter int DB_CYCLES = 500_000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       run_sw,
  input  logic       step_btn,
  input  logic [7:0] bp_addr,
  input  logic [7:0] pc,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [7:0] instr,
  output logic       cpu_en,
  output logic       halted,
  output logic       bp_hit
);

  localparam int TW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    HALT,
    WAIT_TICK,
    FETCH,
    EXEC
  } state_t;

  state_t        state;
  logic          run_meta, run_s;
  logic          step_meta, step_s;
  logic          db_lvl, db_prev;
  logic [DW-1:0] db_cnt;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          step_evt;
  logic          step_mode;
  logic          bp_armed;
  logic          bp_fire;

  assign tick     = (tick_cnt == T_LAST);
  assign step_evt = db_lvl & ~db_prev;

`ifdef CPU_BREAKPOINT_EN
  assign bp_fire = bp_armed && (pc == bp_addr);
`else
  logic unused_bp;
  assign bp_fire   = 1'b0;
  assign unused_bp = ^{bp_addr, bp_armed};
`endif

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      run_meta  <= 1'b0;
      run_s     <= 1'b0;
      step_meta <= 1'b0;
      step_s    <= 1'b0;
      db_lvl    <= 1'b0;
      db_prev   <= 1'b0;
      db_cnt    <= '0;
      tick_cnt  <= '0;
    end else begin
      run_meta  <= run_sw;
      run_s     <= run_meta;
      step_meta <= step_btn;
      step_s    <= step_meta;
      db_prev   <= db_lvl;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      // Any return to the current level restarts the stability window.
      if (step_s == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == D_LAST) begin
        db_lvl <= step_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state     <= HALT;
      imem_req  <= 1'b0;
      imem_addr <= 8'h00;
      instr     <= 8'h00;
      cpu_en    <= 1'b0;
      halted    <= 1'b1;
      bp_hit    <= 1'b0;
      step_mode <= 1'b0;
      bp_armed  <= 1'b1;
    end else begin
      cpu_en <= 1'b0;
      unique case (state)
        HALT: begin
          if (run_s) begin
            state  <= WAIT_TICK;
            halted <= 1'b0;
            bp_hit <= 1'b0;
          end else if (step_evt) begin
            state     <= FETCH;
            step_mode <= 1'b1;
            imem_req  <= 1'b1;
            imem_addr <= pc;
            halted    <= 1'b0;
            bp_hit    <= 1'b0;
          end
        end
        WAIT_TICK: begin
          if (!run_s) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (tick) begin
            if (bp_fire) begin
              // Disarm so the next run/step executes this pc.
              state    <= HALT;
              halted   <= 1'b1;
              bp_hit   <= 1'b1;
              bp_armed <= 1'b0;
            end else begin
              state     <= FETCH;
              step_mode <= 1'b0;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr    <= imem_data;
            imem_req <= 1'b0;
            cpu_en   <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          bp_armed <= 1'b1;
          if (step_mode || !run_s) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= WAIT_TICK;
          end
        end
        default: begin
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule
